// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared parameters, types and requantize helper for the SA row requantizer
package sa_pkg;

  localparam int ROW_LEN = 8;
  localparam int IN_W    = 64;
  localparam int OUT_W   = 8;
  localparam int SH_W    = 6;
  localparam int W_W     = 7;
  localparam int IDX_W   = $clog2(ROW_LEN);
  localparam int QMAX    = 127;
  localparam int QMIN    = -128;

  typedef logic signed [IN_W-1:0]  elem_t;
  typedef logic signed [OUT_W-1:0] qelem_t;
  typedef logic [SH_W-1:0]         shift_t;
  typedef logic [W_W-1:0]          width_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_BUSY
  } drain_state_e;

  // Round half toward +inf, then clamp; one guard bit keeps the rounding add from wrapping.
  function automatic qelem_t requant(elem_t x, shift_t s);
    logic signed [IN_W:0] acc;
    logic signed [IN_W:0] half;
    logic signed [IN_W:0] hi;
    logic signed [IN_W:0] lo;
    acc  = {x[IN_W-1], x};
    half = '0;
    if (s != '0) half[s - shift_t'(1)] = 1'b1;
    acc = (acc + half) >>> s;
    hi  = (IN_W+1)'(QMAX);
    lo  = (IN_W+1)'(QMIN);
    if (acc > hi) return qelem_t'(QMAX);
    if (acc < lo) return qelem_t'(QMIN);
    return acc[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/sa_row_requant_if.sv
// rtl/sa_row_requant_if.sv - input element stream and requantized output stream bundle
interface sa_row_requant_if;
  import sa_pkg::*;

  logic   in_valid;
  elem_t  in_data;
  logic   out_valid;
  qelem_t out_data;
  shift_t out_shift;
  logic   out_last;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_shift, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_shift, out_last
  );

endinterface

// File: rtl/sa_sign_width.sv
// rtl/sa_sign_width.sv - minimal two's-complement width of a signed element
module sa_sign_width
  import sa_pkg::*;
(
  input  elem_t  x_i,
  output width_t w_o
);

  // Highest bit that differs from the sign bit sets the width; no such bit means 0 or -1.
  always_comb begin
    w_o = width_t'(1);
    for (int i = 0; i < IN_W - 1; i++) begin
      if (x_i[i] != x_i[IN_W-1]) w_o = width_t'(i + 2);
    end
  end

endmodule

// File: rtl/sa_row_requant.sv
// rtl/sa_row_requant.sv - per-row power-of-two requantizer of the SA output stream to int8
module sa_row_requant
  import sa_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  sa_row_requant_if.slave bus
);

  typedef logic [IDX_W-1:0] idx_t;

  elem_t        buf_q [2][ROW_LEN];
  logic         fill_sel_q, fill_sel_d;
  idx_t         fill_cnt_q, fill_cnt_d;
  width_t       row_w_q, row_w_d;
  logic [1:0]   full_q, full_d;
  logic         ovf_q, ovf_d;
  drain_state_e drain_state_q, drain_state_d;
  logic         drain_sel_q, drain_sel_d;
  idx_t         drain_idx_q, drain_idx_d;
  shift_t       drain_shift_q, drain_shift_d;
  logic         out_valid_q, out_last_q;
  qelem_t       out_data_q;
  shift_t       out_shift_q;

  width_t in_w, row_w_new;
  shift_t row_shift;
  logic   row_done, row_accept, drain_last;
  logic   load_en, load_last;
  elem_t  load_x;
  shift_t load_shift;

  sa_sign_width u_sign_width (
    .x_i (bus.in_data),
    .w_o (in_w)
  );

  // The arriving element's width joins the row max so a completing row can drain next cycle.
  always_comb begin
    row_w_new  = (in_w > row_w_q) ? in_w : row_w_q;
    row_shift  = (row_w_new > width_t'(OUT_W)) ? shift_t'(row_w_new - width_t'(OUT_W)) : '0;
    row_done   = bus.in_valid && (fill_cnt_q == idx_t'(ROW_LEN - 1));
    row_accept = row_done && !full_q[~fill_sel_q];
    drain_last = (drain_state_q == DRAIN_BUSY) && (drain_idx_q == idx_t'(ROW_LEN - 1));
  end

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    row_w_d    = row_w_q;
    fill_sel_d = fill_sel_q;
    ovf_d      = ovf_q;
    full_d     = full_q;
    if (bus.in_valid) begin
      fill_cnt_d = row_done ? '0 : fill_cnt_q + idx_t'(1);
      row_w_d    = row_done ? '0 : row_w_new;
    end
    if (drain_last) full_d[drain_sel_q] = 1'b0;
    if (row_accept) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = ~fill_sel_q;
    end else if (row_done) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_state_q <= DRAIN_IDLE;
    end else begin
      drain_state_q <= drain_state_d;
    end
  end

  always_comb begin
    drain_state_d = drain_state_q;
    case (drain_state_q)
      DRAIN_IDLE: if (row_accept) drain_state_d = DRAIN_BUSY;
      DRAIN_BUSY: if (drain_last) drain_state_d = DRAIN_IDLE;
      default:    drain_state_d = DRAIN_IDLE;
    endcase
  end

  // Index 0 of a new row is read straight from the fill buffer in its completion cycle.
  always_comb begin
    load_en       = 1'b0;
    load_last     = 1'b0;
    load_x        = buf_q[drain_sel_q][drain_idx_q];
    load_shift    = drain_shift_q;
    drain_sel_d   = drain_sel_q;
    drain_idx_d   = drain_idx_q;
    drain_shift_d = drain_shift_q;
    case (drain_state_q)
      DRAIN_IDLE: begin
        if (row_accept) begin
          load_en       = 1'b1;
          load_x        = buf_q[fill_sel_q][0];
          load_shift    = row_shift;
          drain_sel_d   = fill_sel_q;
          drain_idx_d   = idx_t'(1);
          drain_shift_d = row_shift;
        end
      end
      DRAIN_BUSY: begin
        load_en     = 1'b1;
        load_last   = drain_last;
        drain_idx_d = drain_idx_q + idx_t'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sel_q    <= 1'b0;
      fill_cnt_q    <= '0;
      row_w_q       <= '0;
      full_q        <= '0;
      ovf_q         <= 1'b0;
      drain_sel_q   <= 1'b0;
      drain_idx_q   <= '0;
      drain_shift_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_shift_q   <= '0;
      out_last_q    <= 1'b0;
    end else begin
      fill_sel_q    <= fill_sel_d;
      fill_cnt_q    <= fill_cnt_d;
      row_w_q       <= row_w_d;
      full_q        <= full_d;
      ovf_q         <= ovf_d;
      drain_sel_q   <= drain_sel_d;
      drain_idx_q   <= drain_idx_d;
      drain_shift_q <= drain_shift_d;
      out_valid_q   <= load_en;
      out_data_q    <= load_en ? requant(load_x, load_shift) : '0;
      out_shift_q   <= load_en ? load_shift : '0;
      out_last_q    <= load_last;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) buf_q[fill_sel_q][fill_cnt_q] <= bus.in_data;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_last  = out_last_q;

  // A drop means a row completed while the previous one was still draining.
  assert property (@(posedge clk) disable iff (!rst_n) !ovf_q);

endmodule

// File: tb/tb_sa_row_requant.sv
// tb/tb_sa_row_requant.sv - randomized self-checking bench for sa_row_requant
module tb_sa_row_requant;
  import sa_pkg::*;

  typedef struct packed {
    int     cyc;
    qelem_t d;
    shift_t s;
    logic   l;
  } obs_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   idle_bad;

  obs_t  got_q[$];
  obs_t  exp_q[$];
  elem_t pend_row[$];
  elem_t done_rows[$];
  int    done_e7[$];

  sa_row_requant_if bus ();

  sa_row_requant dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1)
      got_q.push_back('{cyc: cyc, d: bus.out_data, s: bus.out_shift, l: bus.out_last});
    else if ({bus.out_data, bus.out_shift, bus.out_last} !== '0)
      idle_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: width is the smallest w whose arithmetic shift by w-1 leaves only sign bits.
  function automatic int model_w(elem_t x);
    elem_t t;
    for (int w = 1; w <= IN_W; w++) begin
      t = x >>> (w - 1);
      if (t == 0 || t == -1) return w;
    end
    return IN_W;
  endfunction

  function automatic int model_shift(elem_t row [ROW_LEN]);
    int mw;
    mw = 0;
    for (int i = 0; i < ROW_LEN; i++)
      if (model_w(row[i]) > mw) mw = model_w(row[i]);
    return (mw > OUT_W) ? mw - OUT_W : 0;
  endfunction

  // Floor divide, then bump when the discarded remainder is at least half a step.
  function automatic qelem_t model_q(elem_t x, int s);
    logic signed [IN_W+1:0] xe, q, rem, half;
    xe = x;
    if (s == 0) begin
      q = xe;
    end else begin
      q    = xe >>> s;
      rem  = xe - (q <<< s);
      half = 1;
      half = half <<< (s - 1);
      if (rem >= half) q = q + 1;
    end
    if (q > 127) return 8'sd127;
    if (q < -128) return -8'sd128;
    return q[OUT_W-1:0];
  endfunction

  function automatic elem_t rand_elem();
    elem_t r;
    r = {$urandom(), $urandom()};
    return r >>> $urandom_range(63, 0);
  endfunction

  task automatic drive_elem(input elem_t x);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    pend_row.push_back(x);
    if (pend_row.size() == ROW_LEN) begin
      foreach (pend_row[i]) done_rows.push_back(pend_row[i]);
      done_e7.push_back(cyc);
      pend_row.delete();
    end
  endtask

  task automatic wait_drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic build_expected(input int last_n);
    int nrows;
    nrows = done_e7.size();
    for (int r = 0; r < nrows; r++) begin
      elem_t row [ROW_LEN];
      int    s;
      int    n;
      for (int i = 0; i < ROW_LEN; i++) row[i] = done_rows[r*ROW_LEN + i];
      s = model_shift(row);
      n = (r == nrows - 1) ? last_n : ROW_LEN;
      for (int i = 0; i < n; i++)
        exp_q.push_back('{cyc: done_e7[r] + i, d: model_q(row[i], s), s: shift_t'(s),
                          l: (i == ROW_LEN - 1)});
    end
    done_rows.delete();
    done_e7.delete();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %0d required 0", bus.out_data); end
    n_cmp++; if (bus.out_shift !== '0) begin n_bad++; $display("FAIL reset_shift: got %0d required 0", bus.out_shift); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %0b required 0", bus.out_last); end
    n_cmp++; if (dut.ovf_q !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b required 0", dut.ovf_q); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed(input string tag, input elem_t row [ROW_LEN]);
    obs_t e, g;
    for (int i = 0; i < ROW_LEN; i++) drive_elem(row[i]);
    wait_drain();
    build_expected(ROW_LEN);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : '0;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got cyc=%0d data=%0d shift=%0d last=%0b, required cyc=%0d data=%0d shift=%0d last=%0b",
                 tag, g.cyc, g.d, g.s, g.l, e.cyc, e.d, e.s, e.l);
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL %s_extra: got %0d surplus outputs required 0", tag, got_q.size()); got_q.delete(); end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    for (int i = 0; i < 8 * ROW_LEN; i++) drive_elem(rand_elem());
    wait_drain();
    build_expected(ROW_LEN);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : '0;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL back_to_back: got cyc=%0d data=%0d shift=%0d last=%0b, required cyc=%0d data=%0d shift=%0d last=%0b",
                 g.cyc, g.d, g.s, g.l, e.cyc, e.d, e.s, e.l);
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL back_to_back_extra: got %0d surplus outputs required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_gaps();
    obs_t e, g;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        drive_elem(rand_elem());
        if (i == 3) begin
          repeat (3) @(posedge clk);
          #1;
        end
      end
    end
    wait_drain();
    build_expected(ROW_LEN);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : '0;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL gaps: got cyc=%0d data=%0d shift=%0d last=%0b, required cyc=%0d data=%0d shift=%0d last=%0b",
                 g.cyc, g.d, g.s, g.l, e.cyc, e.d, e.s, e.l);
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL gaps_extra: got %0d surplus outputs required 0", got_q.size()); got_q.delete(); end
    n_cmp++; if (dut.ovf_q !== 1'b0) begin n_bad++; $display("FAIL gaps_ovf: got %0b required 0", dut.ovf_q); end
  endtask

  task automatic test_reset_mid_row();
    obs_t e, g;
    for (int i = 0; i < ROW_LEN; i++) drive_elem(elem_t'(3000 * (i + 1)));
    for (int i = 0; i < 5; i++) drive_elem(elem_t'(64'sh10_0000_0000 + i));
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %0b required 1", bus.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_shift, bus.out_last} !== '0) begin
      n_bad++;
      $display("FAIL midrst_async_clear: got valid=%0b data=%0d shift=%0d last=%0b required all 0",
               bus.out_valid, bus.out_data, bus.out_shift, bus.out_last);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pend_row.delete();
    n_cmp++; if (dut.ovf_q !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %0b required 0", dut.ovf_q); end
    // The row draining at reset only got indices 0..4 out before the clear.
    build_expected(5);
    for (int i = 0; i < ROW_LEN; i++) drive_elem(elem_t'($signed($urandom_range(200, 0)) - 100));
    wait_drain();
    build_expected(ROW_LEN);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : '0;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset_mid_row: got cyc=%0d data=%0d shift=%0d last=%0b, required cyc=%0d data=%0d shift=%0d last=%0b",
                 g.cyc, g.d, g.s, g.l, e.cyc, e.d, e.s, e.l);
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL reset_mid_row_extra: got %0d surplus outputs required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_idle_zero();
    n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL idle_zero: got %0d nonzero idle cycles required 0", idle_bad); end
  endtask

  initial begin
    elem_t row [ROW_LEN];
    n_cmp    = 0;
    n_bad    = 0;
    idle_bad = 0;
    test_reset();
    row = '{64'sd0, 64'sd1, -64'sd1, 64'sd127, -64'sd128, 64'sd5, -64'sd5, 64'sd100};
    test_directed("small_range", row);
    row = '{64'sd1000, -64'sd1000, 64'sd12, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
    test_directed("rounding", row);
    row = '{64'sd1023, -64'sd1024, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
    test_directed("saturation", row);
    row[0] = 64'sh8000_0000_0000_0000;
    for (int i = 1; i < ROW_LEN; i++) row[i] = 64'sh7FFF_FFFF_FFFF_FFFF;
    test_directed("extreme", row);
    for (int i = 0; i < ROW_LEN; i++) row[i] = rand_elem();
    test_directed("random_row", row);
    test_back_to_back();
    test_gaps();
    test_reset_mid_row();
    test_idle_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
